// File: rtl/rv32_mem_arbiter.sv
// rv32_mem_arbiter: merges the core's fetch and data ports onto one
// shared req/gnt/rvalid memory bus with in-order response routing.
module rv32_mem_arbiter #(
   parameter int MAX_OUTSTANDING = 2,
   parameter int STARVE_LIMIT    = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   input  logic        data_req_i,
   input  logic [31:0] data_addr_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        resp_err_o
);

   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {
      UNLOCKED,
      LOCKED_I,
      LOCKED_D
   } lock_e;

   lock_e                      lock_q, lock_d;
   logic [3:0]                 streak_q, streak_d;
   logic [MAX_OUTSTANDING-1:0] own_q, own_d;
   logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic                       err_q, err_d;

   logic sel_data;
   logic sel_req;
   logic fifo_full;
   logic fifo_empty;
   logic hs;
   logic pop;
   logic head;

   // Owner select: lock wins, then data priority unless fetch is starved.
   always_comb begin
      sel_data = 1'b1;
      unique case (lock_q)
         LOCKED_I: sel_data = 1'b0;
         LOCKED_D: sel_data = 1'b1;
         default:  sel_data = !(instr_req_i &&
                     (!data_req_i || streak_q == 4'(STARVE_LIMIT)));
      endcase
   end

   assign fifo_full  = (cnt_q == CW'(MAX_OUTSTANDING));
   assign fifo_empty = (cnt_q == '0);
   assign sel_req    = sel_data ? data_req_i : instr_req_i;

   assign mem_req_o   = sel_req && !fifo_full && !rst_i;
   assign mem_addr_o  = sel_data ? data_addr_i : instr_addr_i;
   assign mem_we_o    = sel_data && data_we_i;
   assign mem_be_o    = sel_data ? data_be_i : 4'hF;
   assign mem_wdata_o = sel_data ? data_wdata_i : 32'h0;

   assign hs          = mem_req_o && mem_gnt_i;
   assign instr_gnt_o = hs && !sel_data;
   assign data_gnt_o  = hs && sel_data;

   assign head           = own_q[rd_ptr_q];
   assign pop            = mem_rvalid_i && !fifo_empty && !rst_i;
   assign instr_rvalid_o = pop && !head;
   assign data_rvalid_o  = pop && head;
   assign instr_rdata_o  = mem_rdata_i;
   assign data_rdata_o   = mem_rdata_i;
   assign resp_err_o     = err_q;

   // Lock next state: hold the owner from a stalled request until its grant.
   always_comb begin
      lock_d = lock_q;
      unique case (lock_q)
         UNLOCKED: begin
            if (mem_req_o && !mem_gnt_i)
               lock_d = sel_data ? LOCKED_D : LOCKED_I;
         end
         LOCKED_I, LOCKED_D: begin
            if (hs)
               lock_d = UNLOCKED;
         end
         default: lock_d = UNLOCKED;
      endcase
   end

   // Starvation streak: counts data grants while a fetch is waiting.
   always_comb begin
      streak_d = streak_q;
      if (!instr_req_i)
         streak_d = '0;
      else if (instr_gnt_o)
         streak_d = '0;
      else if (data_gnt_o && streak_q < 4'(STARVE_LIMIT))
         streak_d = streak_q + 4'd1;
   end

   // Owner FIFO and sticky spurious-response flag.
   always_comb begin
      own_d    = own_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      err_d    = err_q;
      if (hs) begin
         own_d[wr_ptr_q] = sel_data;
         wr_ptr_d = (wr_ptr_q == PW'(MAX_OUTSTANDING - 1)) ?
                    '0 : wr_ptr_q + 1'b1;
      end
      if (pop)
         rd_ptr_d = (rd_ptr_q == PW'(MAX_OUTSTANDING - 1)) ?
                    '0 : rd_ptr_q + 1'b1;
      cnt_d = cnt_q + CW'(hs) - CW'(pop);
      if (mem_rvalid_i && fifo_empty)
         err_d = 1'b1;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lock_q   <= UNLOCKED;
         streak_q <= '0;
         own_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         lock_q   <= lock_d;
         streak_q <= streak_d;
         own_q    <= own_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// tb_rv32_mem_arbiter: directed plan cases plus random traffic
// checked against a queue-based reference model.
module tb_rv32_mem_arbiter;

   localparam int MO = 2;
   localparam int SL = 4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o;
   logic        instr_rvalid_o;
   logic [31:0] instr_rdata_o;
   logic        data_req_i;
   logic [31:0] data_addr_i;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_wdata_i;
   logic        data_gnt_o;
   logic        data_rvalid_o;
   logic [31:0] data_rdata_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        resp_err_o;

   rv32_mem_arbiter #(.MAX_OUTSTANDING(MO), .STARVE_LIMIT(SL)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
      .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
      .instr_rdata_o(instr_rdata_o),
      .data_req_i(data_req_i), .data_addr_i(data_addr_i),
      .data_we_i(data_we_i), .data_be_i(data_be_i),
      .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
      .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
      .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .resp_err_o(resp_err_o)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model: owners awaiting a response, in issue order
   bit q_own[$];
   int m_streak = 0;
   bit m_held = 0;
   bit m_hown = 0;
   bit m_err = 0;

   bit e_sel, e_req, e_ig, e_dg, e_irv, e_drv;

   task automatic eval();
      if (m_held) e_sel = m_hown;
      else if (instr_req_i && (!data_req_i || m_streak == SL)) e_sel = 0;
      else e_sel = 1;
      e_req = !rst_i && (e_sel ? data_req_i : instr_req_i) &&
              (q_own.size() < MO);
      e_ig  = e_req && mem_gnt_i && !e_sel;
      e_dg  = e_req && mem_gnt_i && e_sel;
      e_irv = !rst_i && mem_rvalid_i && q_own.size() > 0 && q_own[0] == 0;
      e_drv = !rst_i && mem_rvalid_i && q_own.size() > 0 && q_own[0] == 1;
   endtask

   task automatic update();
      bit granted;
      bit popped;
      if (rst_i) begin
         q_own.delete();
         m_streak = 0;
         m_held = 0;
         m_err = 0;
      end else begin
         granted = e_ig || e_dg;
         popped = mem_rvalid_i && q_own.size() > 0;
         if (mem_rvalid_i && q_own.size() == 0) m_err = 1;
         if (popped) void'(q_own.pop_front());
         if (granted) q_own.push_back(e_sel);
         if (!m_held && e_req && !mem_gnt_i) begin
            m_held = 1;
            m_hown = e_sel;
         end else if (m_held && granted) m_held = 0;
         if (!instr_req_i || e_ig) m_streak = 0;
         else if (e_dg && m_streak < SL) m_streak++;
      end
   endtask

   task automatic tick();
      logic [31:0] wd_got;
      logic [31:0] wd_exp;
      #1;
      eval();
      wd_got = e_sel ? mem_wdata_o : 32'h0;
      wd_exp = e_sel ? data_wdata_i : 32'h0;
      chk("mem_req", 128'(mem_req_o), 128'(e_req));
      chk("bus", {mem_addr_o, mem_we_o, mem_be_o, wd_got},
          {e_sel ? data_addr_i : instr_addr_i, e_sel && data_we_i,
           e_sel ? data_be_i : 4'hF, wd_exp});
      chk("gnt", {instr_gnt_o, data_gnt_o}, {e_ig, e_dg});
      chk("rvalid", {instr_rvalid_o, data_rvalid_o}, {e_irv, e_drv});
      chk("rdata", {instr_rdata_o, data_rdata_o}, {mem_rdata_i, mem_rdata_i});
      chk("err", 128'(resp_err_o), 128'(m_err));
      update();
      @(negedge clk_i);
   endtask

   task automatic idle();
      instr_req_i  = 0;
      instr_addr_i = 0;
      data_req_i   = 0;
      data_addr_i  = 0;
      data_we_i    = 0;
      data_be_i    = 0;
      data_wdata_i = 0;
      mem_gnt_i    = 0;
      mem_rvalid_i = 0;
      mem_rdata_i  = 0;
   endtask

   task automatic do_reset();
      idle();
      rst_i = 1;
      tick();
      rst_i = 0;
   endtask

   initial begin
      rst_i = 1;
      idle();
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      instr_req_i = 1;
      data_req_i  = 1;
      mem_gnt_i   = 1;
      mem_rvalid_i = 1;
      #1;
      chk("rst_force", {mem_req_o, instr_gnt_o, data_gnt_o,
          instr_rvalid_o, data_rvalid_o, resp_err_o}, 6'b0);
      tick();
      do_reset();
      #1;
      chk("post_rst", {mem_req_o, instr_gnt_o, data_gnt_o,
          instr_rvalid_o, data_rvalid_o, resp_err_o}, 6'b0);
      tick();

      // single fetch
      instr_req_i = 1;
      instr_addr_i = 32'h100;
      mem_gnt_i = 1;
      #1;
      chk("fetch_gnt", 128'(instr_gnt_o), 128'(1));
      tick();
      idle();
      tick();
      mem_rvalid_i = 1;
      mem_rdata_i = 32'hDEADBEEF;
      #1;
      chk("fetch_rsp", {instr_rvalid_o, instr_rdata_o, data_rvalid_o},
          {1'b1, 32'hDEADBEEF, 1'b0});
      tick();
      do_reset();

      // starvation limit
      for (int k = 0; k < 10; k++) begin
         instr_req_i = 1;
         instr_addr_i = 32'h1000 + 32'(k);
         data_req_i = 1;
         data_addr_i = 32'h2000;
         mem_gnt_i = 1;
         mem_rvalid_i = q_own.size() > 0;
         #1;
         chk("streak", {instr_gnt_o, data_gnt_o},
             (k == 4 || k == 9) ? 2'b10 : 2'b01);
         tick();
      end
      do_reset();

      // lock holds the stalled data owner
      for (int k = 0; k < 5; k++) begin
         data_req_i = (k <= 3);
         data_addr_i = 32'h200;
         instr_req_i = (k >= 1);
         instr_addr_i = 32'h300;
         mem_gnt_i = (k >= 3);
         #1;
         if (k <= 3) chk("lock_addr", mem_addr_o, 32'h200);
         if (k <= 3) chk("lock_gnt", {instr_gnt_o, data_gnt_o},
                         {1'b0, k == 3});
         else chk("lock_after", {instr_gnt_o, data_gnt_o}, 2'b10);
         tick();
      end
      do_reset();

      // backpressure
      for (int k = 0; k < 5; k++) begin
         data_req_i = 1;
         data_addr_i = 32'h400 + 32'(k);
         instr_req_i = (k >= 2);
         mem_gnt_i = 1;
         mem_rvalid_i = (k == 3);
         #1;
         if (k >= 2) chk("bp_req", {mem_req_o, instr_gnt_o, data_gnt_o},
                         (k == 4) ? 3'b101 : 3'b000);
         tick();
      end
      do_reset();

      // interleaved routing
      for (int k = 0; k < 7; k++) begin
         idle();
         instr_req_i = (k == 0 || k == 3);
         data_req_i = (k == 1);
         mem_gnt_i = (k <= 3);
         mem_rvalid_i = (k == 2 || k == 4 || k == 5);
         mem_rdata_i = (k == 2) ? 32'hA : (k == 4) ? 32'hB : 32'hC;
         #1;
         if (k == 2) chk("rt_a", {instr_rvalid_o, data_rvalid_o}, 2'b10);
         if (k == 4) chk("rt_b", {instr_rvalid_o, data_rvalid_o,
                         data_rdata_o}, {2'b01, 32'hB});
         if (k == 5) chk("rt_c", {instr_rvalid_o, data_rvalid_o}, 2'b10);
         tick();
      end

      // spurious response and reset
      idle();
      mem_rvalid_i = 1;
      #1;
      chk("spur_rv", {instr_rvalid_o, data_rvalid_o}, 2'b00);
      tick();
      idle();
      #1;
      chk("err_set", 128'(resp_err_o), 128'(1));
      tick();
      tick();
      chk("err_hold", 128'(resp_err_o), 128'(1));
      do_reset();
      #1;
      chk("err_clr", 128'(resp_err_o), 128'(0));
      tick();

      // random traffic
      begin
         bit last_ig = 0;
         bit last_dg = 0;
         idle();
         for (int c = 0; c < 3000; c++) begin
            if (instr_req_i && last_ig) instr_req_i = 0;
            if (!instr_req_i && $urandom_range(0, 2) == 0) begin
               instr_req_i = 1;
               instr_addr_i = $urandom;
            end
            if (data_req_i && last_dg) data_req_i = 0;
            if (!data_req_i && $urandom_range(0, 2) == 0) begin
               data_req_i = 1;
               data_addr_i = $urandom;
               data_we_i = 1'($urandom);
               data_be_i = 4'($urandom);
               data_wdata_i = $urandom;
            end
            mem_gnt_i = ($urandom_range(0, 3) != 0);
            mem_rvalid_i = (q_own.size() > 0) && ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 300) == 0) mem_rvalid_i = 1;
            mem_rdata_i = $urandom;
            rst_i = ($urandom_range(0, 250) == 0);
            tick();
            last_ig = e_ig || rst_i;
            last_dg = e_dg || rst_i;
            if (rst_i) begin
               instr_req_i = 0;
               data_req_i = 0;
            end
            rst_i = 0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
